user_grant_read: RTL and testbench

Read-side access gate for the user-protected 8-bit data register. It accepts read requests tagged with a user ID over a valid/ready handshake and returns the register contents only to the granted user. Other users get zero data and an error flag. Repeated denied reads trigger a timed lockout. It sits between requesting agents and the protected register's read path.

---
 rtl/user_grant_read_if.sv | 23 ++
 rtl/user_grant_read.sv | 93 +++++++++
 tb/tb_user_grant_read.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/user_grant_read_if.sv
// Read-request / response handshake bundle for the user-protected register gate.
interface user_grant_read_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 3
);
  logic              rd_valid;
  logic [ID_W-1:0]   usr_id;
  logic              rd_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output rd_valid, usr_id, resp_ready,
    input  rd_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  rd_valid, usr_id, resp_ready,
    output rd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/user_grant_read.sv
// Read-side access gate: only GRANT_ID sees the register; repeated denials
// trigger a fixed-length lockout.
module user_grant_read #(
  parameter int unsigned     DATA_W      = 8,
  parameter int unsigned     ID_W        = 3,
  parameter logic [ID_W-1:0] GRANT_ID    = ID_W'(4),
  parameter int unsigned     MAX_FAILS   = 3,
  parameter int unsigned     LOCK_CYCLES = 16,
  localparam int unsigned    FC_W        = $clog2(MAX_FAILS + 1),
  localparam int unsigned    LC_W        = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] reg_value,
  user_grant_read_if.slave  bus,
  output logic              locked,
  output logic [FC_W-1:0]   fail_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_LOCK
  } state_t;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   lock_cnt;
  logic              at_max;

  assign at_max = (fail_cnt == FC_W'(MAX_FAILS));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.rd_ready   = 1'b0;
    bus.resp_valid = 1'b0;
    locked         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.rd_ready = 1'b1;
        if (bus.rd_valid) state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = at_max ? S_LOCK : S_IDLE;
      end
      S_LOCK: begin
        locked = 1'b1;
        // <=1 rather than ==1 so a corrupted zero count cannot wedge the lock
        if (lock_cnt <= LC_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.resp_data <= '0;
      bus.resp_err  <= 1'b0;
      fail_cnt      <= '0;
      lock_cnt      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rd_valid) begin
            if (bus.usr_id == GRANT_ID) begin
              bus.resp_data <= reg_value;
              bus.resp_err  <= 1'b0;
              fail_cnt      <= '0;
            end else begin
              bus.resp_data <= '0;
              bus.resp_err  <= 1'b1;
              if (!at_max) fail_cnt <= fail_cnt + FC_W'(1);
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready && at_max) lock_cnt <= LC_W'(LOCK_CYCLES);
        end
        S_LOCK: begin
          lock_cnt <= lock_cnt - LC_W'(1);
          if (lock_cnt <= LC_W'(1)) fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_grant_read.sv
// Self-checking bench for user_grant_read: transaction-level reference model
// checked every cycle, plus directed reads with literal expectations.
module tb_user_grant_read;
  localparam int GRANT = 4;
  localparam int MAXF  = 3;
  localparam int LOCKN = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] reg_value;
  logic       locked;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  user_grant_read_if #(.DATA_W(8), .ID_W(3)) bus ();

  user_grant_read #(
    .DATA_W(8), .ID_W(3), .GRANT_ID(3'h4), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_value(reg_value), .bus(bus.slave),
    .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending response, a remaining-lockout count, a run of denials.
  bit         m_ok = 0;
  bit         m_pend = 0;
  int         m_lock_rem = 0;
  int         m_fails = 0;
  logic [7:0] m_data = '0;
  logic       m_err = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ok = 1; m_pend = 0; m_lock_rem = 0; m_fails = 0; m_data = '0; m_err = 1'b0;
    end else if (m_ok) begin
      if (m_lock_rem > 0) begin
        m_lock_rem--;
        if (m_lock_rem == 0) m_fails = 0;
      end else if (m_pend) begin
        if (bus.resp_ready) begin
          m_pend = 0;
          if (m_fails == MAXF) m_lock_rem = LOCKN;
        end
      end else if (bus.rd_valid) begin
        m_pend = 1;
        if (int'(bus.usr_id) == GRANT) begin
          m_data = reg_value; m_err = 1'b0; m_fails = 0;
        end else begin
          m_data = '0; m_err = 1'b1;
          m_fails = (m_fails >= MAXF) ? MAXF : m_fails + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_rd_ready",   32'(bus.rd_ready),   32'(!m_pend && m_lock_rem == 0));
      chk("m_resp_valid", 32'(bus.resp_valid), 32'(m_pend));
      chk("m_locked",     32'(locked),         32'(m_lock_rem > 0));
      chk("m_fail_cnt",   32'(fail_cnt),       32'(m_fails));
      chk("m_resp_data",  32'(bus.resp_data),  32'(m_data));
      chk("m_resp_err",   32'(bus.resp_err),   32'(m_err));
    end
  end

  task automatic wait_resp();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin ok = 1; break; end
    end
    chk("resp_timeout", 32'(ok), 32'd1);
  endtask

  task automatic rd(input logic [2:0] id, input logic [7:0] v,
                    input logic [7:0] ed, input logic ee, input logic [1:0] ef);
    bus.usr_id = id; reg_value = v; bus.rd_valid = 1'b1; bus.resp_ready = 1'b1;
    wait_resp();
    bus.rd_valid = 1'b0; bus.usr_id = 3'($urandom);
    chk("rd_data", 32'(bus.resp_data), 32'(ed));
    chk("rd_err",  32'(bus.resp_err),  32'(ee));
    chk("rd_fcnt", 32'(fail_cnt),      32'(ef));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset();
    chk("rst_rd_ready",   32'(bus.rd_ready),   32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data",  32'(bus.resp_data),  32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_locked",     32'(locked),         32'd0);
    chk("rst_fail_cnt",   32'(fail_cnt),       32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset();
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; bus.rd_valid = 1'b0; bus.usr_id = '0; bus.resp_ready = 1'b1; reg_value = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset();

    // Granted read, then ready again after the handshake
    rd(3'd4, 8'hA5, 8'hA5, 1'b0, 2'd0);
    @(negedge clk);
    chk("ready_after_hs", 32'(bus.rd_ready), 32'd1);

    // Denial count 1,2,0,1 with no lockout
    rd(3'd2, 8'h3C, 8'h00, 1'b1, 2'd1);
    rd(3'd6, 8'h3C, 8'h00, 1'b1, 2'd2);
    rd(3'd4, 8'h96, 8'h96, 1'b0, 2'd0);
    rd(3'd3, 8'h96, 8'h00, 1'b1, 2'd1);
    @(negedge clk);
    chk("no_lock", 32'(locked), 32'd0);
    rd(3'd4, 8'h01, 8'h01, 1'b0, 2'd0);

    // Three denials -> 16-cycle lockout; a held granted request waits it out
    rd(3'd1, 8'hF0, 8'h00, 1'b1, 2'd1);
    rd(3'd5, 8'hF0, 8'h00, 1'b1, 2'd2);
    rd(3'd7, 8'hF0, 8'h00, 1'b1, 2'd3);
    bus.usr_id = 3'd4; reg_value = 8'h5A; bus.rd_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!locked) break;
      cnt++;
    end
    chk("lock_len", 32'(cnt), 32'd16);
    wait_resp();
    bus.rd_valid = 1'b0;
    chk("post_lock_data", 32'(bus.resp_data), 32'h5A);
    chk("post_lock_err",  32'(bus.resp_err),  32'd0);
    chk("post_lock_fcnt", 32'(fail_cnt),      32'd0);
    @(posedge clk); #1;

    // Backpressure: data captured at accept, held while reg_value moves
    bus.resp_ready = 1'b0; bus.usr_id = 3'd4; reg_value = 8'h11; bus.rd_valid = 1'b1;
    wait_resp();
    bus.rd_valid = 1'b0; reg_value = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_data",  32'(bus.resp_data),  32'h11);
      chk("bp_ready", 32'(bus.rd_ready),   32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.rd_ready),   32'd1);
    chk("bp_hold_data",  32'(bus.resp_data),  32'h11);

    // Reset mid-RESP
    bus.resp_ready = 1'b0; bus.usr_id = 3'd2; reg_value = 8'h77; bus.rd_valid = 1'b1;
    wait_resp();
    bus.rd_valid = 1'b0;
    chk("mid_resp_err", 32'(bus.resp_err), 32'd1);
    @(posedge clk); #1;
    pulse_reset();
    bus.resp_ready = 1'b1;

    // Reset mid-LOCK
    rd(3'd1, 8'h00, 8'h00, 1'b1, 2'd1);
    rd(3'd5, 8'h00, 8'h00, 1'b1, 2'd2);
    rd(3'd7, 8'h00, 8'h00, 1'b1, 2'd3);
    repeat (3) @(negedge clk);
    chk("mid_lock", 32'(locked), 32'd1);
    pulse_reset();
    rd(3'd4, 8'hC3, 8'hC3, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
